// File: rtl/mdio_pkg.sv
// ============================================================================
//  Package     : mdio_pkg
//  Description : Shared constants, frame field layout and FSM state encoding
//                for the MDIO peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdio_pkg;

  // Frame geometry: a 16-bit header (ST/OP/PHYAD/REGAD/TA) then 16 data bits
  localparam int FRAME_W = 32;
  localparam int HDR_W   = 16;
  localparam int DATA_W  = FRAME_W - HDR_W;
  localparam int CNT_W   = 5;

  // Header field codes
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_WDATA  = 3'd2,
    S_RDATA  = 3'd3,
    S_DROP   = 3'd4
  } state_e;

  // Header layout, MSB (first bit on the wire) first
  typedef struct packed {
    logic [1:0] st;
    logic [1:0] op;
    logic [4:0] phyad;
    logic [4:0] regad;
    logic [1:0] ta;
  } hdr_t;

endpackage

`default_nettype wire

// File: rtl/mdio_mdc_edge.sv
// ============================================================================
//  Module      : mdio_mdc_edge
//  Description : Holds the previous MDC sample and flags the clk cycle in
//                which MDC is seen high after having been low.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   system clock, rising edge
//    reset      in   synchronous, active-low reset (clears MDC history)
//    mdc_i      in   management clock, already synchronous to clk
//    mdc_rise_o out  high for the one clk where MDC=1 and history=0
// ============================================================================
`default_nettype none

module mdio_mdc_edge (
  input  logic clk,
  input  logic reset,
  input  logic mdc_i,
  output logic mdc_rise_o
);

  logic mdc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mdc_q <= 1'b0;
    end else begin
      mdc_q <= mdc_i;
    end
  end

  assign mdc_rise_o = mdc_i & ~mdc_q;

endmodule

`default_nettype wire

// File: rtl/mdio_peripheral.sv
// ============================================================================
//  Module      : mdio_peripheral
//  Description : MDIO management-frame receiver. Decodes the 16-bit header,
//                issues one-clk write/read strobes to a register file and
//                serialises read data back to the generator.
//  Revision    : 1.0 - initial release
//
//  Build option
//    MDIO_PHY_ADDR_FILTER_EN  when defined, valid frames whose PHYAD differs
//                             from PHY_ADDR are dropped silently; otherwise
//                             PHYAD is ignored.
//
//  Ports
//    clk        in   system clock, rising edge
//    reset      in   synchronous, active-low reset
//    MDC        in   management clock (<= clk/2, synchronous to clk)
//    MDIO_OUT   in   serial data from generator, MSB first
//    MDIO_OE    in   high while the generator drives MDIO_OUT
//    RD_DATA    in   register-file read data, valid one clk after MEM_RD
//    MDIO_IN    out  serial read data to generator, MSB first
//    ADDR       out  REGAD of the current frame
//    WR_DATA    out  data word of the last completed write frame
//    MEM_WR     out  one-clk write strobe
//    MEM_RD     out  one-clk read strobe
//    BUSY       out  high whenever the FSM is not IDLE
//    FRAME_ERR  out  one-clk pulse on a malformed or aborted frame
// ============================================================================
`default_nettype none

module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        MEM_WR,
  output logic        MEM_RD,
  output logic        BUSY,
  output logic        FRAME_ERR
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(DATA_W);

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [DATA_W-1:0]   shift_q,     shift_d;
  logic [4:0]          addr_q,      addr_d;
  logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
  logic                mdio_in_q,   mdio_in_d;
  logic                mem_wr_q,    mem_wr_d;
  logic                mem_rd_q,    mem_rd_d;
  logic                frame_err_q, frame_err_d;
  logic                rd_pend_q,   rd_pend_d;

  logic                w_mdc_rise;
  logic [DATA_W-1:0]   w_shift_in;
  hdr_t                w_hdr;
  logic                w_st_ok;
  logic                w_op_wr;
  logic                w_op_rd;
  logic                w_phy_ok;
  logic                w_unused;

  mdio_mdc_edge u_mdc_edge (
    .clk        (clk),
    .reset      (reset),
    .mdc_i      (MDC),
    .mdc_rise_o (w_mdc_rise)
  );

  // The word as it will look once the current MDIO_OUT bit is shifted in;
  // on the 16th header rise this is the complete header.
  assign w_shift_in = {shift_q[DATA_W-2:0], MDIO_OUT};
  assign w_hdr      = w_shift_in;
  assign w_st_ok    = (w_hdr.st == ST_START);
  assign w_op_wr    = (w_hdr.op == OP_WRITE);
  assign w_op_rd    = (w_hdr.op == OP_READ);

`ifdef MDIO_PHY_ADDR_FILTER_EN
  assign w_phy_ok = (w_hdr.phyad == PHY_ADDR);
  assign w_unused = ^w_hdr.ta;
`else
  assign w_phy_ok = 1'b1;
  assign w_unused = ^{w_hdr.ta, w_hdr.phyad, PHY_ADDR};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      mdio_in_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      mdio_in_q   <= mdio_in_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      frame_err_q <= frame_err_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    mdio_in_d   = mdio_in_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    frame_err_d = 1'b0;
    // Marks the clk in which RD_DATA answers the previous MEM_RD
    rd_pend_d   = mem_rd_q;

    case (state_q)
      S_IDLE: begin
        if (w_mdc_rise && MDIO_OE) begin
          shift_d = {{(DATA_W-1){1'b0}}, MDIO_OUT};
          cnt_d   = CNT_ONE;
          state_d = S_HEADER;
        end
      end

      S_HEADER: begin
        if (!MDIO_OE) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else if (w_mdc_rise) begin
          shift_d = w_shift_in;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == BIT_LAST) begin
            addr_d = w_hdr.regad;
            cnt_d  = '0;
            if (w_st_ok && w_op_wr && w_phy_ok) begin
              state_d = S_WDATA;
            end else if (w_st_ok && w_op_rd && w_phy_ok) begin
              mem_rd_d = 1'b1;
              state_d  = S_RDATA;
            end else begin
              // A well-formed frame for another PHY is skipped quietly
              frame_err_d = !(w_st_ok && (w_op_wr || w_op_rd));
              state_d     = S_DROP;
            end
          end
        end
      end

      S_WDATA: begin
        // Completion wins over OE: the generator may release the line
        // right after the last data bit.
        if (cnt_q == BIT_FULL) begin
          wr_data_d = shift_q;
          mem_wr_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (!MDIO_OE) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else if (w_mdc_rise) begin
          shift_d = w_shift_in;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      S_RDATA: begin
        // cnt_q == 0 means the word is not loaded yet; MDC rises are
        // ignored until RD_DATA has been captured.
        if (rd_pend_q) begin
          shift_d   = RD_DATA;
          mdio_in_d = RD_DATA[DATA_W-1];
          cnt_d     = CNT_ONE;
        end else if (w_mdc_rise && (cnt_q != '0)) begin
          if (cnt_q == BIT_FULL) begin
            mdio_in_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            mdio_in_d = shift_q[DATA_W-2];
            cnt_d     = cnt_q + CNT_ONE;
          end
        end
      end

      S_DROP: begin
        if (w_mdc_rise) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        cnt_d     = '0;
        mdio_in_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign MDIO_IN   = mdio_in_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;
  assign MEM_WR    = mem_wr_q;
  assign MEM_RD    = mem_rd_q;
  assign BUSY      = (state_q != S_IDLE);
  assign FRAME_ERR = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_peripheral.sv
// ============================================================================
//  Module      : tb_mdio_peripheral
//  Description : Self-checking bench for mdio_peripheral. Frames are driven
//                bit by bit on MDC; a frame-level model predicts strobes,
//                errors, address, write data and the serial read word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdio_peripheral;

  localparam logic [4:0] TB_PHY = 5'd1;
`ifdef MDIO_PHY_ADDR_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        MDC      = 1'b0;
  logic        MDIO_OUT = 1'b0;
  logic        MDIO_OE  = 1'b0;
  logic [15:0] RD_DATA;
  logic        MDIO_IN;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        MEM_WR;
  logic        MEM_RD;
  logic        BUSY;
  logic        FRAME_ERR;

  mdio_peripheral #(.PHY_ADDR(TB_PHY)) dut (
    .clk       (clk),
    .reset     (reset),
    .MDC       (MDC),
    .MDIO_OUT  (MDIO_OUT),
    .MDIO_OE   (MDIO_OE),
    .RD_DATA   (RD_DATA),
    .MDIO_IN   (MDIO_IN),
    .ADDR      (ADDR),
    .WR_DATA   (WR_DATA),
    .MEM_WR    (MEM_WR),
    .MEM_RD    (MEM_RD),
    .BUSY      (BUSY),
    .FRAME_ERR (FRAME_ERR)
  );

  always #5 clk = ~clk;

  // Register file: data appears the clk after MEM_RD is sampled
  logic [15:0] regfile [32];
  always @(posedge clk) begin
    if (!reset) RD_DATA <= 16'h0;
    else if (MEM_RD) RD_DATA <= regfile[ADDR];
  end

  // Strobe monitor (free-running counters; frames use deltas)
  int          n_wr = 0, n_rd = 0, n_err = 0, n_both = 0;
  logic [4:0]  mon_waddr = 5'd0, mon_raddr = 5'd0;
  always @(negedge clk) begin
    if (MEM_WR) begin n_wr++; mon_waddr = ADDR; end
    if (MEM_RD) begin n_rd++; mon_raddr = ADDR; end
    if (FRAME_ERR) n_err++;
    if (MEM_WR && MEM_RD) n_both++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state carried between frames
  logic [4:0]  model_addr  = 5'd0;
  logic [15:0] model_wdata = 16'h0;

  // Drive one frame. oe_bits = number of leading bits with MDIO_OE high;
  // 32 MDC periods are always generated.
  task automatic run_frame(input logic [31:0] f, input int oe_bits);
    logic [1:0]  st, op;
    logic [4:0]  phy, regad;
    logic        valid, phy_ok, wr_acc, rd_acc, aborted;
    logic        exp_err, exp_wr, exp_rd, exp_busy;
    logic [15:0] exp_serial, serial;
    int          w0, r0, e0, b0;
    st     = f[31:30];
    op     = f[29:28];
    phy    = f[27:23];
    regad  = f[22:18];
    valid  = (st == 2'b01) && (op == 2'b01 || op == 2'b10);
    phy_ok = !FILTER || (phy == TB_PHY);
    wr_acc = valid && (op == 2'b01) && phy_ok;
    rd_acc = valid && (op == 2'b10) && phy_ok;
    aborted  = (oe_bits < 16) || (wr_acc && oe_bits < 32);
    exp_err  = aborted || !valid;
    exp_wr   = wr_acc && (oe_bits >= 32);
    exp_rd   = rd_acc && (oe_bits >= 16);
    exp_busy = !aborted;
    exp_serial = exp_rd ? regfile[regad] : 16'h0;
    if (oe_bits >= 16) model_addr = regad;
    if (exp_wr) model_wdata = f[15:0];

    w0 = n_wr; r0 = n_rd; e0 = n_err; b0 = n_both;
    serial = 16'h0;
    for (int i = 0; i < 32; i++) begin
      if (i < oe_bits) begin MDIO_OE = 1'b1; MDIO_OUT = f[31-i]; end
      else begin MDIO_OE = 1'b0; MDIO_OUT = 1'b0; end
      if (i == oe_bits) begin
        @(negedge clk);
        check_eq("busy_after_oe_drop", 32'(BUSY), 32'(exp_busy));
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      if (i >= 16) serial = {serial[14:0], MDIO_IN};
      if (i == 31) check_eq("busy_before_last_rise", 32'(BUSY), 32'(exp_busy));
      MDC = 1'b1;
      repeat (4) @(negedge clk);
      MDC = 1'b0;
    end
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b0;
    repeat (8) @(negedge clk);

    check_eq("mem_wr_pulses", 32'(n_wr - w0), 32'(exp_wr));
    check_eq("mem_rd_pulses", 32'(n_rd - r0), 32'(exp_rd));
    check_eq("frame_err_pulses", 32'(n_err - e0), 32'(exp_err));
    check_eq("wr_rd_same_clk", 32'(n_both - b0), 32'd0);
    check_eq("mdio_in_serial", 32'(serial), 32'(exp_serial));
    check_eq("addr", 32'(ADDR), 32'(model_addr));
    check_eq("wr_data", 32'(WR_DATA), 32'(model_wdata));
    check_eq("mdio_in_idle", 32'(MDIO_IN), 32'd0);
    check_eq("busy_end", 32'(BUSY), 32'd0);
    if (exp_wr) check_eq("wr_strobe_addr", 32'(mon_waddr), 32'(regad));
    if (exp_rd) check_eq("rd_strobe_addr", 32'(mon_raddr), 32'(regad));
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_bit(input logic oe, input logic d);
    MDIO_OE  = oe;
    MDIO_OUT = d;
    repeat (4) @(negedge clk);
    MDC = 1'b1;
    repeat (4) @(negedge clk);
    MDC = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    logic [1:0]  st, op;
    logic [4:0]  phy;
    int          oe, e0;

    for (int i = 0; i < 32; i++) regfile[i] = 16'($urandom);
    regfile[3] = 16'h1234;

    // Reset state
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_mdio_in", 32'(MDIO_IN), 32'd0);
    check_eq("rst_addr", 32'(ADDR), 32'd0);
    check_eq("rst_wr_data", 32'(WR_DATA), 32'd0);
    check_eq("rst_mem_wr", 32'(MEM_WR), 32'd0);
    check_eq("rst_mem_rd", 32'(MEM_RD), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Directed frames
    run_frame(32'h500EA5A5, 32);   // write REGAD 3 (PHYAD 0)
    run_frame(32'h600E0000, 16);   // read REGAD 3 (PHYAD 0)
    run_frame(32'h608E0000, 32);   // read PHYAD 1, OE kept high in data
    run_frame(32'h100EA5A5, 32);   // bad ST
    run_frame(32'h500EA5A5, 20);   // OE dropped mid write data
    run_frame(32'h508EA5A5, 32);   // write PHYAD 1
    run_frame(32'h700E0000, 32);   // bad OP
    run_frame(32'h508E1234, 9);    // OE dropped in header

    // Reset in the middle of write data
    f = 32'h508EA5A5;
    for (int i = 0; i < 24; i++) drive_bit(1'b1, f[31-i]);
    e0 = n_err;
    reset   = 1'b0;
    MDIO_OE = 1'b0;
    @(negedge clk);
    check_eq("midframe_rst_outputs",
             32'({MDIO_IN, ADDR, WR_DATA, MEM_WR, MEM_RD, BUSY, FRAME_ERR}), 32'd0);
    reset = 1'b1;
    model_addr  = 5'd0;
    model_wdata = 16'h0;
    repeat (8) @(negedge clk);
    check_eq("midframe_rst_no_err", 32'(n_err - e0), 32'd0);
    run_frame(32'h500E0001, 32);
    run_frame(32'h508E0001, 32);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      st  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      op  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3))
                                        : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      case ($urandom_range(0, 2))
        0:       phy = 5'd0;
        1:       phy = TB_PHY;
        default: phy = 5'($urandom);
      endcase
      f  = {st, op, phy, 5'($urandom), 2'b10, 16'($urandom)};
      oe = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31))
                                       : ((op == 2'b10) ? 16 : 32);
      run_frame(f, oe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
